// File: rtl/vrom_pkg.sv
// Shared types and default geometry for the vertex ROM and its arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package vrom_pkg;

   localparam int VROM_ADDR_W  = 16;
   localparam int VROM_DATA_W  = 96;
   localparam int VROM_LATENCY = 2;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } vertex_t;

   typedef logic [VROM_ADDR_W-1:0] vrom_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
// Latency: grant is combinational; the pointer advances on the edge after an accepted grant.
// Backpressure: the pointer only moves when accept is high, so an unaccepted grant costs nothing.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic [N-1:0]  req_vld,
   input  logic          accept,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q;
   logic [IW:0]   cand_sum;
   logic [IW-1:0] cand;
   logic          found;

   // Scan N candidates starting at the pointer; the first requesting one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand_sum  = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand_sum = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand_sum >= (IW+1)'(N)) begin
            cand_sum = cand_sum - (IW+1)'(N);
         end
         cand = cand_sum[IW-1:0];
         if (!found && req_vld[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // The winner drops to lowest priority; with no handshake the pointer holds.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/vertex_rom_arbiter.sv
// Shares one registered-read vertex ROM between NUM_REQ fetch engines, round-robin, one grant per cycle.
// Latency: grant and ROM address same cycle; response ROM_LATENCY cycles after the handshake.
// Backpressure: none on responses; requesters wait for req_ready_out. Optional perf counters: VROM_ARB_PERF_CNT_EN.
module vertex_rom_arbiter
   import vrom_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = VROM_ADDR_W,
   parameter int DATA_W      = VROM_DATA_W,
   parameter int ROM_LATENCY = VROM_LATENCY
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   output logic [ADDR_W-1:0]              rom_addr_out,
   input  logic [DATA_W-1:0]              rom_data_in,
   output logic [NUM_REQ-1:0]             rsp_valid_out,
   output logic [DATA_W-1:0]              rsp_data_out,
   output logic                           busy_out
`ifdef VROM_ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ-1:0][31:0]       grant_cnt_out,
   output logic [NUM_REQ-1:0][31:0]       stall_cnt_out
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               hs;
   logic [ADDR_W-1:0]  last_addr_q;
   logic [NUM_REQ-1:0] tag_q [ROM_LATENCY];
   logic               tag_any;
   logic               busy_q;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .req_vld   (req_valid_in),
      .accept    (hs),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // The arbiter only grants valid requesters, so any grant is a handshake.
   assign req_ready_out = grant;
   assign hs            = |(req_valid_in & grant);

   // Idle cycles replay the last granted address so the ROM address bus stays quiet.
   assign rom_addr_out  = hs ? req_addr_in[grant_idx] : last_addr_q;

   // Remember the most recently granted address.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         last_addr_q <= '0;
      end else if (hs) begin
         last_addr_q <= req_addr_in[grant_idx];
      end
   end

   // Tag pipeline mirrors the ROM read pipeline so each word returns to its owner.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < ROM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= grant;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Any occupied tag stage means a read is still in flight.
   always_comb begin
      tag_any = 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
         tag_any = tag_any | (|tag_q[i]);
      end
   end

   // Busy is registered, so it trails the request inputs by one cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= (|req_valid_in) | tag_any;
      end
   end

   assign busy_out      = busy_q;
   assign rsp_valid_out = tag_q[ROM_LATENCY-1];
   assign rsp_data_out  = rom_data_in;

`ifdef VROM_ARB_PERF_CNT_EN
   // Per-requester handshake and stall counters, free-running with natural wrap.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         grant_cnt_out <= '0;
         stall_cnt_out <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_in[i] && grant[i]) begin
               grant_cnt_out[i] <= grant_cnt_out[i] + 32'd1;
            end
            if (req_valid_in[i] && !grant[i]) begin
               stall_cnt_out[i] <= stall_cnt_out[i] + 32'd1;
            end
         end
      end
   end
`endif

endmodule
